// File: rtl/stream_stat_mon.sv
// Passive AXI-stream statistics monitor: per-channel transfer, stall, packet and longest-burst
// counters with sticky overflow flags, stretched activity indicators and one registered readout.
module stream_stat_mon #(
  parameter int N_CH        = 2,
  parameter int CNT_W       = 16,
  parameter bit SAT         = 1'b1,
  parameter int ACT_STRETCH = 5_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  ch_vld,
  input  logic [N_CH-1:0]  ch_rdy,
  input  logic [N_CH-1:0]  ch_last,
  input  logic             clr,
  input  logic             freeze,
  input  logic [2:0]       sel_ch,
  input  logic [1:0]       sel_mode,
  output logic [CNT_W-1:0] stat_o,
  output logic [N_CH-1:0]  ovf,
  output logic [N_CH-1:0]  active
);

  localparam int SW = (ACT_STRETCH < 1) ? 1 : $clog2(ACT_STRETCH + 1);

  logic [2:0]       rst_sync;
  logic             run_en;
  logic             was_frozen;
  logic [N_CH-1:0]  xfer;
  logic [N_CH-1:0]  stall;

  logic [CNT_W-1:0] xfer_cnt  [N_CH];
  logic [CNT_W-1:0] stall_cnt [N_CH];
  logic [CNT_W-1:0] pkt_cnt   [N_CH];
  logic [CNT_W-1:0] burst_max [N_CH];
  logic [CNT_W-1:0] burst_cur [N_CH];

  logic [CNT_W-1:0] xfer_nxt  [N_CH];
  logic [CNT_W-1:0] stall_nxt [N_CH];
  logic [CNT_W-1:0] pkt_nxt   [N_CH];
  logic [CNT_W-1:0] bmax_nxt  [N_CH];
  logic [CNT_W-1:0] bcur_nxt  [N_CH];
  logic [N_CH-1:0]  ovf_nxt;

  logic [CNT_W:0]   tmp_x;
  logic [CNT_W:0]   tmp_s;
  logic [CNT_W:0]   tmp_p;
  logic [CNT_W:0]   tmp_b;
  logic [CNT_W-1:0] burst_base;
  logic [CNT_W-1:0] stat_sel;

  logic [SW-1:0]    stretch [N_CH];

  // Returns {overflow, next value}; at all-ones the counter either holds or wraps.
  function automatic logic [CNT_W:0] bump(input logic [CNT_W-1:0] v);
    if (&v) return {1'b1, (SAT ? v : {CNT_W{1'b0}})};
    return {1'b0, v + 1'b1};
  endfunction

  assign xfer   = ch_vld & ch_rdy;
  assign stall  = ch_vld & ~ch_rdy;
  assign run_en = rst_sync[2];

  // Release of the async reset is retimed; counting starts once the last stage is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 3'b000;
    else        rst_sync <= {rst_sync[1:0], 1'b1};
  end

  always_comb begin
    tmp_x      = '0;
    tmp_s      = '0;
    tmp_p      = '0;
    tmp_b      = '0;
    burst_base = '0;
    ovf_nxt    = ovf;
    for (int i = 0; i < N_CH; i++) begin
      xfer_nxt[i]  = xfer_cnt[i];
      stall_nxt[i] = stall_cnt[i];
      pkt_nxt[i]   = pkt_cnt[i];
      bmax_nxt[i]  = burst_max[i];
      bcur_nxt[i]  = burst_cur[i];
      if (clr) begin
        xfer_nxt[i]  = '0;
        stall_nxt[i] = '0;
        pkt_nxt[i]   = '0;
        bmax_nxt[i]  = '0;
        bcur_nxt[i]  = '0;
        ovf_nxt[i]   = 1'b0;
      end else if (!freeze && run_en) begin
        // A burst interrupted by freeze is not continued afterwards.
        burst_base = was_frozen ? '0 : burst_cur[i];
        if (xfer[i]) begin
          tmp_x       = bump(xfer_cnt[i]);
          xfer_nxt[i] = tmp_x[CNT_W-1:0];
          tmp_b       = bump(burst_base);
          bcur_nxt[i] = tmp_b[CNT_W-1:0];
          if (tmp_b[CNT_W-1:0] > burst_max[i]) bmax_nxt[i] = tmp_b[CNT_W-1:0];
          if (ch_last[i]) begin
            tmp_p      = bump(pkt_cnt[i]);
            pkt_nxt[i] = tmp_p[CNT_W-1:0];
          end
          if (tmp_x[CNT_W] || tmp_b[CNT_W] || (ch_last[i] && tmp_p[CNT_W])) ovf_nxt[i] = 1'b1;
        end else begin
          bcur_nxt[i] = '0;
          if (stall[i]) begin
            tmp_s        = bump(stall_cnt[i]);
            stall_nxt[i] = tmp_s[CNT_W-1:0];
            if (tmp_s[CNT_W]) ovf_nxt[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        xfer_cnt[i]  <= '0;
        stall_cnt[i] <= '0;
        pkt_cnt[i]   <= '0;
        burst_max[i] <= '0;
        burst_cur[i] <= '0;
      end
      ovf        <= '0;
      was_frozen <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        xfer_cnt[i]  <= xfer_nxt[i];
        stall_cnt[i] <= stall_nxt[i];
        pkt_cnt[i]   <= pkt_nxt[i];
        burst_max[i] <= bmax_nxt[i];
        burst_cur[i] <= bcur_nxt[i];
      end
      ovf        <= ovf_nxt;
      was_frozen <= freeze & ~clr;
    end
  end

  // Activity stretch ignores freeze; only clr and reset cut it short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) stretch[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (clr)                        stretch[i] <= '0;
        else if (run_en && xfer[i])     stretch[i] <= SW'(ACT_STRETCH);
        else if (stretch[i] != '0)      stretch[i] <= stretch[i] - 1'b1;
      end
    end
  end

  always_comb begin
    active = '0;
    for (int i = 0; i < N_CH; i++) active[i] = |stretch[i];
  end

  always_comb begin
    stat_sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel_ch == 3'(i)) begin
        case (sel_mode)
          2'b00:   stat_sel = xfer_cnt[i];
          2'b01:   stat_sel = stall_cnt[i];
          2'b10:   stat_sel = pkt_cnt[i];
          default: stat_sel = burst_max[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stat_o <= '0;
    else        stat_o <= stat_sel;
  end

endmodule

// File: tb/tb_stream_stat_mon.sv
// Bench for stream_stat_mon: a saturating and a wrapping instance share stimulus and are
// compared with directed constants and a count-based reference model.
module tb_stream_stat_mon;

  localparam int N_CH = 2;
  localparam int CNT_W = 8;
  localparam int ACT = 4;
  localparam int CMAX = 255;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [N_CH-1:0]  ch_vld = '0;
  logic [N_CH-1:0]  ch_rdy = '0;
  logic [N_CH-1:0]  ch_last = '0;
  logic             clr = 1'b0;
  logic             freeze = 1'b0;
  logic [2:0]       sel_ch = '0;
  logic [1:0]       sel_mode = '0;
  logic [CNT_W-1:0] stat_s, stat_w;
  logic [N_CH-1:0]  ovf_s, ovf_w, act_s, act_w;

  always #5 clk = ~clk;

  stream_stat_mon #(.N_CH(N_CH), .CNT_W(CNT_W), .SAT(1'b1), .ACT_STRETCH(ACT)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ch_vld(ch_vld), .ch_rdy(ch_rdy), .ch_last(ch_last),
    .clr(clr), .freeze(freeze), .sel_ch(sel_ch), .sel_mode(sel_mode),
    .stat_o(stat_s), .ovf(ovf_s), .active(act_s));

  stream_stat_mon #(.N_CH(N_CH), .CNT_W(CNT_W), .SAT(1'b0), .ACT_STRETCH(ACT)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .ch_vld(ch_vld), .ch_rdy(ch_rdy), .ch_last(ch_last),
    .clr(clr), .freeze(freeze), .sel_ch(sel_ch), .sel_mode(sel_mode),
    .stat_o(stat_w), .ovf(ovf_w), .active(act_w));

  int checks = 0;
  int errors = 0;

  // Reference model: unbounded event counts since the last clear, reduced to counter width on read.
  int m_xfer[N_CH], m_stall[N_CH], m_pkt[N_CH], m_run[N_CH], m_max[N_CH], m_act[N_CH];
  int edges = 0;
  int exp_stat_s = 0;
  int exp_stat_w = 0;

  function automatic int model_stat(int ch, int mode, bit sat);
    int c;
    if (ch >= N_CH) return 0;
    case (mode)
      0: c = m_xfer[ch];
      1: c = m_stall[ch];
      2: c = m_pkt[ch];
      default: return (m_max[ch] > CMAX) ? CMAX : m_max[ch];
    endcase
    if (sat) return (c > CMAX) ? CMAX : c;
    return c % (CMAX + 1);
  endfunction

  function automatic logic [N_CH-1:0] model_ovf();
    logic [N_CH-1:0] r = '0;
    for (int i = 0; i < N_CH; i++)
      r[i] = (m_xfer[i] > CMAX) || (m_stall[i] > CMAX) || (m_pkt[i] > CMAX) || (m_max[i] > CMAX);
    return r;
  endfunction

  function automatic logic [N_CH-1:0] model_act();
    logic [N_CH-1:0] r = '0;
    for (int i = 0; i < N_CH; i++) r[i] = (m_act[i] > 0);
    return r;
  endfunction

  task automatic model_clear_ch(input int i);
    m_xfer[i] = 0; m_stall[i] = 0; m_pkt[i] = 0; m_run[i] = 0; m_max[i] = 0; m_act[i] = 0;
  endtask

  // One clock edge: the model consumes the inputs seen at the edge, then outputs settle.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      exp_stat_s = 0;
      exp_stat_w = 0;
    end else begin
      exp_stat_s = model_stat(int'(sel_ch), int'(sel_mode), 1'b1);
      exp_stat_w = model_stat(int'(sel_ch), int'(sel_mode), 1'b0);
      edges++;
      for (int i = 0; i < N_CH; i++) begin
        if (clr) model_clear_ch(i);
        else begin
          if (edges >= 4 && !freeze) begin
            if (ch_vld[i] && ch_rdy[i]) begin
              m_xfer[i]++;
              m_run[i]++;
              if (m_run[i] > m_max[i]) m_max[i] = m_run[i];
              if (ch_last[i]) m_pkt[i]++;
            end else begin
              m_run[i] = 0;
              if (ch_vld[i]) m_stall[i]++;
            end
          end else if (freeze) m_run[i] = 0;
          if (edges >= 4 && ch_vld[i] && ch_rdy[i]) m_act[i] = ACT;
          else if (m_act[i] > 0) m_act[i]--;
        end
      end
    end
    #1;
  endtask

  task automatic assert_reset();
    #2 rst_n = 1'b0;
    for (int i = 0; i < N_CH; i++) model_clear_ch(i);
    edges = 0;
    exp_stat_s = 0;
    exp_stat_w = 0;
    #1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    assert_reset();
    tick();
    tick();
    checks++;
    if (stat_s !== '0 || stat_w !== '0) begin
      errors++; $display("[TB] FAIL reset_stat: got %0d/%0d, expected 0", stat_s, stat_w);
    end
    checks++;
    if (ovf_s !== '0 || ovf_w !== '0 || act_s !== '0 || act_w !== '0) begin
      errors++; $display("[TB] FAIL reset_flags: got ovf %b/%b act %b/%b, expected 0", ovf_s, ovf_w, act_s, act_w);
    end
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_basic();
    int exp_b[4] = '{14, 3, 1, 10};
    sel_ch = 3'd0;
    ch_vld = 2'b01; ch_rdy = 2'b01; ch_last = 2'b00;
    repeat (10) tick();
    ch_rdy = 2'b00;
    repeat (3) tick();
    ch_rdy = 2'b01;
    repeat (3) tick();
    ch_last = 2'b01;
    tick();
    ch_vld = '0; ch_rdy = '0; ch_last = '0;
    for (int m = 0; m < 4; m++) begin
      sel_mode = 2'(m);
      tick();
      checks++;
      if (int'(stat_s) !== exp_b[m] || int'(stat_w) !== exp_b[m]) begin
        errors++; $display("[TB] FAIL basic_mode%0d: got %0d/%0d, expected %0d", m, stat_s, stat_w, exp_b[m]);
      end
    end
    sel_ch = 3'd1; sel_mode = 2'd0;
    tick();
    checks++;
    if (stat_s !== '0) begin
      errors++; $display("[TB] FAIL basic_ch1_idle: got %0d, expected 0", stat_s);
    end
  endtask

  task automatic test_saturation();
    pulse_clr();
    sel_ch = 3'd1; sel_mode = 2'd0;
    ch_vld = 2'b10; ch_rdy = 2'b10;
    repeat (300) tick();
    ch_vld = '0; ch_rdy = '0;
    tick();
    checks++;
    if (int'(stat_s) !== 255) begin
      errors++; $display("[TB] FAIL sat_value: got %0d, expected 255", stat_s);
    end
    checks++;
    if (int'(stat_w) !== 44) begin
      errors++; $display("[TB] FAIL wrap_value: got %0d, expected 44", stat_w);
    end
    checks++;
    if (ovf_s !== 2'b10 || ovf_w !== 2'b10) begin
      errors++; $display("[TB] FAIL sat_ovf: got %b/%b, expected 10", ovf_s, ovf_w);
    end
  endtask

  task automatic test_clr();
    sel_ch = 3'd0;
    ch_vld = 2'b01; ch_rdy = 2'b01;
    repeat (20) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    ch_vld = '0; ch_rdy = '0;
    checks++;
    if (ovf_s !== '0 || ovf_w !== '0 || act_s !== '0) begin
      errors++; $display("[TB] FAIL clr_flags: got ovf %b/%b act %b, expected 0", ovf_s, ovf_w, act_s);
    end
    for (int m = 0; m < 4; m++) begin
      sel_mode = 2'(m);
      tick();
      checks++;
      if (stat_s !== '0 || stat_w !== '0) begin
        errors++; $display("[TB] FAIL clr_mode%0d: got %0d/%0d, expected 0", m, stat_s, stat_w);
      end
    end
    sel_mode = 2'd0;
    ch_vld = 2'b01; ch_rdy = 2'b01;
    tick();
    ch_vld = '0; ch_rdy = '0;
    tick();
    checks++;
    if (int'(stat_s) !== 1) begin
      errors++; $display("[TB] FAIL clr_next_xfer: got %0d, expected 1", stat_s);
    end
  endtask

  task automatic test_freeze();
    pulse_clr();
    sel_ch = 3'd0; sel_mode = 2'd0;
    ch_vld = 2'b01; ch_rdy = 2'b01;
    repeat (5) tick();
    freeze = 1'b1;
    repeat (3) tick();
    freeze = 1'b0;
    repeat (2) tick();
    ch_vld = '0; ch_rdy = '0;
    freeze = 1'b1;
    tick();
    checks++;
    if (int'(stat_s) !== 7) begin
      errors++; $display("[TB] FAIL freeze_xfer: got %0d, expected 7", stat_s);
    end
    sel_mode = 2'd3;
    tick();
    checks++;
    if (int'(stat_s) !== 5) begin
      errors++; $display("[TB] FAIL freeze_burst: got %0d, expected 5", stat_s);
    end
    freeze = 1'b0;
  endtask

  task automatic test_sel_range();
    sel_mode = 2'd0;
    sel_ch = 3'd5;
    tick();
    checks++;
    if (stat_s !== '0 || stat_w !== '0) begin
      errors++; $display("[TB] FAIL sel_ch5: got %0d/%0d, expected 0", stat_s, stat_w);
    end
    sel_ch = 3'd0;
    tick();
    checks++;
    if (int'(stat_s) !== 7) begin
      errors++; $display("[TB] FAIL sel_ch0: got %0d, expected 7", stat_s);
    end
    sel_ch = 3'd7;
    tick();
    checks++;
    if (stat_s !== '0) begin
      errors++; $display("[TB] FAIL sel_ch7: got %0d, expected 0", stat_s);
    end
  endtask

  task automatic test_active();
    pulse_clr();
    repeat (2) tick();
    ch_vld = 2'b01; ch_rdy = 2'b01;
    tick();
    ch_vld = '0; ch_rdy = '0;
    for (int j = 0; j < 6; j++) begin
      checks++;
      if (act_s[0] !== (j < 4) || act_w[0] !== (j < 4)) begin
        errors++; $display("[TB] FAIL active_stretch%0d: got %b/%b, expected %b", j, act_s[0], act_w[0], (j < 4));
      end
      tick();
    end
    freeze = 1'b1;
    ch_vld = 2'b01; ch_rdy = 2'b01;
    tick();
    freeze = 1'b0;
    ch_vld = '0; ch_rdy = '0;
    checks++;
    if (act_s[0] !== 1'b1) begin
      errors++; $display("[TB] FAIL active_freeze: got %b, expected 1", act_s[0]);
    end
  endtask

  task automatic test_reset_midburst();
    pulse_clr();
    sel_ch = 3'd0; sel_mode = 2'd0;
    ch_vld = 2'b01; ch_rdy = 2'b01;
    repeat (5) tick();
    freeze = 1'b1;
    clr = 1'b1;
    assert_reset();
    checks++;
    if (stat_s !== '0 || stat_w !== '0 || ovf_s !== '0 || act_s !== '0 || act_w !== '0) begin
      errors++; $display("[TB] FAIL midreset_async: got stat %0d/%0d ovf %b act %b/%b, expected 0", stat_s, stat_w, ovf_s, act_s, act_w);
    end
    tick();
    freeze = 1'b0;
    clr = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (act_s !== '0) begin
      errors++; $display("[TB] FAIL midreset_early_active: got %b, expected 00", act_s);
    end
    tick();
    ch_vld = '0; ch_rdy = '0;
    checks++;
    if (stat_s !== '0) begin
      errors++; $display("[TB] FAIL midreset_early_count: got %0d, expected 0", stat_s);
    end
    tick();
    checks++;
    if (int'(stat_s) !== 1) begin
      errors++; $display("[TB] FAIL midreset_fourth_edge: got %0d, expected 1", stat_s);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      ch_vld   = 2'($urandom);
      ch_rdy   = 2'($urandom);
      ch_last  = 2'($urandom);
      freeze   = ($urandom_range(0, 7) == 0);
      clr      = ($urandom_range(0, 63) == 0);
      sel_ch   = 3'($urandom_range(0, 3));
      sel_mode = 2'($urandom);
      tick();
      checks++;
      if (int'(stat_s) !== exp_stat_s || int'(stat_w) !== exp_stat_w) begin
        errors++; $display("[TB] FAIL rand_stat@%0d: got %0d/%0d, expected %0d/%0d", n, stat_s, stat_w, exp_stat_s, exp_stat_w);
      end
      checks++;
      if (ovf_s !== model_ovf() || ovf_w !== model_ovf()) begin
        errors++; $display("[TB] FAIL rand_ovf@%0d: got %b/%b, expected %b", n, ovf_s, ovf_w, model_ovf());
      end
      checks++;
      if (act_s !== model_act() || act_w !== model_act()) begin
        errors++; $display("[TB] FAIL rand_active@%0d: got %b/%b, expected %b", n, act_s, act_w, model_act());
      end
    end
    ch_vld = '0; ch_rdy = '0; ch_last = '0; freeze = 1'b0; clr = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N_CH; i++) model_clear_ch(i);
    test_reset();
    test_basic();
    test_saturation();
    test_clr();
    test_freeze();
    test_sel_range();
    test_active();
    test_reset_midburst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
